// File: rtl/dv_checkpoint_seq_monitor.sv
// dv_checkpoint_seq_monitor
// Debounces a checkpoint bus sampled from the chip under test and walks it
// through a programmable ordered list of expected codes. The result is
// reported as sticky PASS / FAIL status with a reason code, and the monitor
// also keeps a saturating count of cycles elapsed since start.
module dv_checkpoint_seq_monitor #(
   parameter int CW         = 16,
   parameter int NSTAGE     = 8,
   parameter int TMO_W      = 24,
   parameter int STABLE_CYC = 2
) (
   input  logic                       wb_clk_i,
   input  logic                       wb_rst_i,
   input  logic                       start_i,
   input  logic [CW-1:0]              checkbits_i,
   input  logic [NSTAGE*CW-1:0]       exp_codes_i,
   input  logic [$clog2(NSTAGE+1)-1:0] num_stages_i,
   input  logic [CW-1:0]              fail_code_i,
   input  logic                       fail_en_i,
   input  logic [TMO_W-1:0]           timeout_i,
   output logic                       busy_o,
   output logic [$clog2(NSTAGE+1)-1:0] stage_o,
   output logic                       stage_hit_o,
   output logic                       pass_o,
   output logic                       fail_o,
   output logic [1:0]                 reason_o,
   output logic [CW-1:0]              last_code_o,
   output logic [TMO_W-1:0]           elapsed_o
);

   localparam int SW    = $clog2(NSTAGE + 1);
   localparam int CNT_W = $clog2(STABLE_CYC + 1);

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYC);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [SW-1:0]    NSTAGE_V = SW'(NSTAGE);

   localparam logic [1:0] REASON_NONE    = 2'b00;
   localparam logic [1:0] REASON_TIMEOUT = 2'b01;
   localparam logic [1:0] REASON_FAILCD  = 2'b10;
   localparam logic [1:0] REASON_BADCFG  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_PASS,
      S_FAIL
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     prev_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic              accept;
   logic [SW-1:0]     stage_q, stage_d;
   logic [TMO_W-1:0]  elapsed_q, elapsed_d;
   logic              pass_q, pass_d;
   logic              fail_q, fail_d;
   logic [1:0]        reason_q, reason_d;
   logic              hit_q, hit_d;
   logic [CW-1:0]     last_q, last_d;
   logic [CW-1:0]     exp_cur;

   logic start_ok;
   logic bad_cfg;
   logic code_match;
   logic fail_hit;
   logic tmo_hit;
   logic last_stage;

   // A start request is only honoured when no sequence is in flight.
   assign start_ok = start_i && (state_q != S_RUN);

   assign bad_cfg    = (num_stages_i == '0) || (num_stages_i > NSTAGE_V);
   assign last_stage = (stage_q == (num_stages_i - 1'b1));
   assign code_match = accept && (checkbits_i == exp_cur);
   assign fail_hit   = accept && fail_en_i && (checkbits_i == fail_code_i) &&
                       (checkbits_i != exp_cur);
   assign tmo_hit    = (timeout_i != '0) && (elapsed_q == (timeout_i - 1'b1));

   // Glitch filter: count consecutive equal samples; accept once per stable value.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      cnt_d   = cnt_q;
      accept  = 1'b0;
      cnt_inc = cnt_q + 1'b1;
      if (checkbits_i != prev_q) begin
         cnt_d  = CNT_ONE;
         accept = (CNT_MAX == CNT_ONE);
      end else if (cnt_q != CNT_MAX) begin
         cnt_d  = cnt_inc;
         accept = (cnt_inc == CNT_MAX);
      end
      // A fresh run forces whatever is on the bus to re-qualify from scratch.
      if (start_ok) begin
         cnt_d  = '0;
         accept = 1'b0;
      end
   end

   // Select the expected code for the current stage.
   always_comb begin
      exp_cur = '0;
      for (int k = 0; k < NSTAGE; k++) begin
         if (stage_q == SW'(k)) begin
            exp_cur = exp_codes_i[k*CW +: CW];
         end
      end
   end

   // Next-state and status logic; expected match beats fail code beats timeout.
   always_comb begin
      state_d   = state_q;
      stage_d   = stage_q;
      elapsed_d = elapsed_q;
      pass_d    = pass_q;
      fail_d    = fail_q;
      reason_d  = reason_q;
      hit_d     = 1'b0;
      last_d    = accept ? checkbits_i : last_q;

      case (state_q)
         S_RUN: begin
            if (elapsed_q != '1) begin
               elapsed_d = elapsed_q + 1'b1;
            end
            if (code_match) begin
               hit_d   = 1'b1;
               stage_d = stage_q + 1'b1;
               if (last_stage) begin
                  state_d = S_PASS;
                  pass_d  = 1'b1;
               end
            end else if (fail_hit) begin
               state_d  = S_FAIL;
               fail_d   = 1'b1;
               reason_d = REASON_FAILCD;
            end else if (tmo_hit) begin
               state_d  = S_FAIL;
               fail_d   = 1'b1;
               reason_d = REASON_TIMEOUT;
            end
         end
         default: begin
            if (start_ok) begin
               stage_d   = '0;
               elapsed_d = '0;
               pass_d    = 1'b0;
               fail_d    = 1'b0;
               reason_d  = REASON_NONE;
               if (bad_cfg) begin
                  state_d  = S_FAIL;
                  fail_d   = 1'b1;
                  reason_d = REASON_BADCFG;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
      endcase
   end

   // State and status registers, cleared asynchronously.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      if (wb_rst_i) begin
         // NOTE: the filter's previous-sample register is reset too, so the first sample compares against a known 0.
         state_q   <= S_IDLE;
         prev_q    <= '0;
         cnt_q     <= '0;
         stage_q   <= '0;
         elapsed_q <= '0;
         pass_q    <= 1'b0;
         fail_q    <= 1'b0;
         reason_q  <= REASON_NONE;
         hit_q     <= 1'b0;
         last_q    <= '0;
      end else begin
         state_q   <= state_d;
         prev_q    <= checkbits_i;
         cnt_q     <= cnt_d;
         stage_q   <= stage_d;
         elapsed_q <= elapsed_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
         reason_q  <= reason_d;
         hit_q     <= hit_d;
         last_q    <= last_d;
      end
   end

   assign busy_o      = (state_q == S_RUN);
   assign stage_o     = stage_q;
   assign stage_hit_o = hit_q;
   assign pass_o      = pass_q;
   assign fail_o      = fail_q;
   assign reason_o    = reason_q;
   assign last_code_o = last_q;
   assign elapsed_o   = elapsed_q;

endmodule
